// File: rtl/color_blob_tracker.sv
// color_blob_tracker
//   Counts in-band ("hit") pixels of the filtered video, together with their
//   row/column sums and bounding box. At each vertical-sync falling edge it
//   snapshots the frame statistics, computes the centroid with two parallel
//   restoring dividers and publishes the results for downstream logic.
//   Optional feature macro: COLOR_BLOB_CROSSHAIR_EN draws a red crosshair
//   over the published centroid. When it is undefined, video passes through.
module color_blob_tracker #(
    parameter int MIN_PIXELS = 64,
    parameter int H_ACT      = 640,
    parameter int V_ACT      = 480
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [7:0]  pix_R,
    input  logic [7:0]  pix_G,
    input  logic [7:0]  pix_B,
    input  logic [12:0] row,
    input  logic [12:0] col,
    input  logic        VGA_VS,
    output logic [7:0]  o_R,
    output logic [7:0]  o_G,
    output logic [7:0]  o_B,
    output logic [9:0]  cent_row,
    output logic [9:0]  cent_col,
    output logic [9:0]  bb_top,
    output logic [9:0]  bb_bot,
    output logic [9:0]  bb_left,
    output logic [9:0]  bb_right,
    output logic [18:0] pix_count,
    output logic        obj_valid,
    output logic        frame_done
);

    localparam int CNT_W     = 19;
    localparam int SUM_W     = 28;
    localparam int SUM_X     = SUM_W + 1;
    localparam int REM_X     = CNT_W + 1;
    localparam int DIV_ITERS = 28;

    typedef enum logic [1:0] {ACCUM, DIVIDE, PUBLISH} state_t;

    state_t state, next_state;

    // Frame accumulators
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum_r, sum_c;
    logic [9:0]       min_row, max_row, min_col, max_col;

    // Snapshot / divider work registers
    logic [CNT_W-1:0] w_cnt;
    logic             w_valid;
    logic [SUM_W-1:0] q_r, q_c;
    logic [CNT_W-1:0] rem_r, rem_c;
    logic [9:0]       w_min_row, w_max_row, w_min_col, w_max_col;
    logic [4:0]       iter;

    logic vs_d;

    // Pixel classification
    logic [23:0] pix;
    logic        in_active, is_marker, hit;

    assign pix       = {pix_R, pix_G, pix_B};
    assign in_active = (row < 13'(V_ACT)) && (col < 13'(H_ACT));
    assign is_marker = (pix == 24'hFFFFFF) || (pix == 24'h00FF00) || (pix == 24'h0000FF);
    assign hit       = in_active && !is_marker;

    // Frame edge and the decision whether the snapshot is worth dividing
    logic frame_edge, start, snap_valid, div_last;

    assign frame_edge = !VGA_VS && vs_d;
    assign start      = frame_edge && (state == ACCUM);
    assign snap_valid = (cnt >= CNT_W'(MIN_PIXELS)) && (cnt != '0);
    assign div_last   = (iter == 5'(DIV_ITERS - 1));

    // Saturating accumulator arithmetic
    logic [SUM_X-1:0] sum_r_add, sum_c_add;

    assign sum_r_add = {1'b0, sum_r} + SUM_X'(row);
    assign sum_c_add = {1'b0, sum_c} + SUM_X'(col);

    // One restoring-division step for each of the two dividers
    logic [REM_X-1:0] sh_r, sh_c, diff_r, diff_c;
    logic             ge_r, ge_c;

    assign sh_r   = {rem_r, q_r[SUM_W-1]};
    assign sh_c   = {rem_c, q_c[SUM_W-1]};
    assign ge_r   = sh_r >= {1'b0, w_cnt};
    assign ge_c   = sh_c >= {1'b0, w_cnt};
    assign diff_r = sh_r - {1'b0, w_cnt};
    assign diff_c = sh_c - {1'b0, w_cnt};

    // Top difference bit is zero whenever it is selected (remainder < divisor).
    logic unused_bits;
    assign unused_bits = ^{diff_r[REM_X-1], diff_c[REM_X-1]};

    // Register VGA_VS so its falling edge can be detected
    always_ff @(posedge vga_clk) begin
        // NOTE: sequential state always uses non-blocking (<=) so every
        // register samples the pre-edge values of the others.
        if (!reset_n) vs_d <= 1'b0;
        else          vs_d <= VGA_VS;
    end

    // FSM state register
    always_ff @(posedge vga_clk) begin
        if (!reset_n) state <= ACCUM;
        else          state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        // NOTE: default first so no path through the case leaves next_state
        // unassigned, which would infer a latch.
        next_state = state;
        unique case (state)
            ACCUM:   if (frame_edge) next_state = snap_valid ? DIVIDE : PUBLISH;
            DIVIDE:  if (div_last)   next_state = PUBLISH;
            PUBLISH: next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Per-frame accumulation of hit count, coordinate sums and bounding box
    always_ff @(posedge vga_clk) begin
        if (!reset_n || start) begin
            cnt     <= '0;
            sum_r   <= '0;
            sum_c   <= '0;
            min_row <= 10'h3FF;
            min_col <= 10'h3FF;
            max_row <= '0;
            max_col <= '0;
        end else if (hit) begin
            if (cnt != '1) cnt <= cnt + 1'b1;
            sum_r <= sum_r_add[SUM_W] ? '1 : sum_r_add[SUM_W-1:0];
            sum_c <= sum_c_add[SUM_W] ? '1 : sum_c_add[SUM_W-1:0];
            if (row[9:0] < min_row) min_row <= row[9:0];
            if (row[9:0] > max_row) max_row <= row[9:0];
            if (col[9:0] < min_col) min_col <= col[9:0];
            if (col[9:0] > max_col) max_col <= col[9:0];
        end
    end

    // Snapshot at the frame edge, then one quotient bit per DIVIDE cycle
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            w_cnt     <= '0;
            w_valid   <= 1'b0;
            q_r       <= '0;
            q_c       <= '0;
            rem_r     <= '0;
            rem_c     <= '0;
            iter      <= '0;
            w_min_row <= '0;
            w_max_row <= '0;
            w_min_col <= '0;
            w_max_col <= '0;
        end else if (start) begin
            w_cnt     <= cnt;
            w_valid   <= snap_valid;
            q_r       <= sum_r;
            q_c       <= sum_c;
            rem_r     <= '0;
            rem_c     <= '0;
            iter      <= '0;
            w_min_row <= min_row;
            w_max_row <= max_row;
            w_min_col <= min_col;
            w_max_col <= max_col;
        end else if (state == DIVIDE) begin
            q_r   <= {q_r[SUM_W-2:0], ge_r};
            q_c   <= {q_c[SUM_W-2:0], ge_c};
            rem_r <= ge_r ? diff_r[CNT_W-1:0] : sh_r[CNT_W-1:0];
            rem_c <= ge_c ? diff_c[CNT_W-1:0] : sh_c[CNT_W-1:0];
            iter  <= iter + 1'b1;
        end
    end

    // Publish registered results; centroid and box only on a valid frame
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            cent_row   <= '0;
            cent_col   <= '0;
            bb_top     <= '0;
            bb_bot     <= '0;
            bb_left    <= '0;
            bb_right   <= '0;
            pix_count  <= '0;
            obj_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == PUBLISH) begin
                frame_done <= 1'b1;
                pix_count  <= w_cnt;
                obj_valid  <= w_valid;
                if (w_valid) begin
                    cent_row <= q_r[9:0];
                    cent_col <= q_c[9:0];
                    bb_top   <= w_min_row;
                    bb_bot   <= w_max_row;
                    bb_left  <= w_min_col;
                    bb_right <= w_max_col;
                end
            end
        end
    end

`ifdef COLOR_BLOB_CROSSHAIR_EN
    // Crosshair: +/-8 pixel arms around the published centroid
    logic [13:0] row_x, col_x, cr_x, cc_x;
    logic        near_row, near_col, on_cross;

    assign row_x    = {1'b0, row};
    assign col_x    = {1'b0, col};
    assign cr_x     = {4'b0, cent_row};
    assign cc_x     = {4'b0, cent_col};
    assign near_row = (row_x + 14'd8 >= cr_x) && (row_x <= cr_x + 14'd8);
    assign near_col = (col_x + 14'd8 >= cc_x) && (col_x <= cc_x + 14'd8);
    assign on_cross = obj_valid && in_active &&
                      (((row_x == cr_x) && near_col) || ((col_x == cc_x) && near_row));

    assign {o_R, o_G, o_B} = on_cross ? 24'hFF0000 : pix;
`else
    // Pure pass-through video
    assign {o_R, o_G, o_B} = pix;
`endif

endmodule
